// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants and helpers for the memory controller.
//   - access length codes for LSB requests
//   - controller state and request-source encodings
//   - IO region tag compared against addr[17:16]
//   - len_to_n(): access length code -> number of bytes on the bus
package mem_ctrl_pkg;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    // Addresses whose bits [17:16] equal this tag belong to the UART/IO region.
    localparam logic [1:0] IO_HI = 2'b11;

    typedef enum logic [1:0] {
        MC_IDLE  = 2'd0,
        MC_READ  = 2'd1,
        MC_WRITE = 2'd2,
        MC_DONE  = 2'd3
    } mc_state_t;

    typedef enum logic {
        SRC_IC  = 1'b0,
        SRC_LSB = 1'b1
    } mc_src_t;

    // Byte count of an access; the illegal code 3 is handled as a word.
    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            LEN_B:   n = 3'd1;
            LEN_H:   n = 3'd2;
            LEN_W:   n = 3'd4;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetches and LSB loads/stores onto a
// byte-wide synchronous RAM/IO bus, one byte per cycle, and returns the
// assembled result with a one-cycle valid pulse.
//
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (low = freeze)
//   mem_din / mem_dout / mem_a / mem_wr : byte bus to RAM/IO (1-cycle read latency)
//   io_buffer_full                       : UART buffer full, blocks IO stores
//   icache_ask/addr -> icache_valid/inst : word fetch port
//   lsb_ask/wr/addr/len/wdata -> lsb_valid/rdata : load/store port
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter bit LSB_PRIORITY = 1'b1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full,
    input  logic                  icache_ask,
    input  logic [ADDR_WIDTH-1:0] icache_addr,
    output logic                  icache_valid,
    output logic [31:0]           icache_inst,
    input  logic                  lsb_ask,
    input  logic                  lsb_wr,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [1:0]            lsb_len,
    input  logic [31:0]           lsb_wdata,
    output logic                  lsb_valid,
    output logic [31:0]           lsb_rdata
);

    mc_state_t             state_r, state_s;
    mc_src_t               src_r, src_s;
    logic [ADDR_WIDTH-1:0] base_r, base_s;
    logic [2:0]            n_r, n_s;
    logic [2:0]            ic_r, ic_s;
    logic [2:0]            rc_r, rc_s;
    logic [31:0]           wdata_r, wdata_s;
    logic [31:0]           asm_r, asm_s;
    // pipe_r[0]: an address was issued on the last edge; pipe_r[1]: two edges ago,
    // so its byte is on mem_din now.
    logic [1:0]            pipe_r, pipe_s;
    // Set by any frozen edge; the first edge after a freeze restarts a READ.
    logic                  frz_r;
    logic [ADDR_WIDTH-1:0] mem_a_r, mem_a_s;
    logic [7:0]            mem_dout_r, mem_dout_s;
    logic                  mem_wr_r, mem_wr_s;
    logic                  icache_valid_r, icache_valid_s;
    logic [31:0]           icache_inst_r, icache_inst_s;
    logic                  lsb_valid_r, lsb_valid_s;
    logic [31:0]           lsb_rdata_r, lsb_rdata_s;

    logic                  issue_s;
    logic [31:0]           asm_nxt_s;
    logic                  io_block_s;
    logic                  lsb_ok_s;
    logic                  pick_lsb_s;
    logic                  pick_ic_s;

    // A store into the IO region cannot start while the UART buffer is full.
    assign io_block_s = lsb_wr & (lsb_addr[17:16] == IO_HI) & io_buffer_full;
    assign lsb_ok_s   = lsb_ask & ~io_block_s;
    assign pick_lsb_s = LSB_PRIORITY ? lsb_ok_s : (lsb_ok_s & ~icache_ask);
    assign pick_ic_s  = icache_ask & ~pick_lsb_s;

    assign mem_a        = mem_a_r;
    assign mem_dout     = mem_dout_r;
    // Gate the strobe so a frozen cycle never repeats an IO write.
    assign mem_wr       = mem_wr_r & rdy_in;
    assign icache_valid = icache_valid_r;
    assign icache_inst  = icache_inst_r;
    assign lsb_valid    = lsb_valid_r;
    assign lsb_rdata    = lsb_rdata_r;

    // Next-state, serialiser and byte assembly.
    always_comb begin
        state_s        = state_r;
        src_s          = src_r;
        base_s         = base_r;
        n_s            = n_r;
        ic_s           = ic_r;
        rc_s           = rc_r;
        wdata_s        = wdata_r;
        asm_s          = asm_r;
        pipe_s         = pipe_r;
        mem_a_s        = mem_a_r;
        mem_dout_s     = mem_dout_r;
        mem_wr_s       = mem_wr_r;
        icache_valid_s = 1'b0;
        icache_inst_s  = icache_inst_r;
        lsb_valid_s    = 1'b0;
        lsb_rdata_s    = lsb_rdata_r;
        issue_s        = 1'b0;
        asm_nxt_s      = asm_r;
        asm_nxt_s[{rc_r[1:0], 3'b000} +: 8] = mem_din;

        case (state_r)
            MC_IDLE: begin
                if (pick_lsb_s) begin
                    src_s   = SRC_LSB;
                    base_s  = lsb_addr;
                    n_s     = len_to_n(lsb_len);
                    wdata_s = lsb_wdata;
                    mem_a_s = lsb_addr;
                    ic_s    = 3'd1;
                    rc_s    = 3'd0;
                    asm_s   = 32'd0;
                    if (lsb_wr) begin
                        mem_dout_s = lsb_wdata[7:0];
                        mem_wr_s   = 1'b1;
                        pipe_s     = 2'b00;
                        state_s    = MC_WRITE;
                    end else begin
                        mem_wr_s   = 1'b0;
                        pipe_s     = 2'b01;
                        state_s    = MC_READ;
                    end
                end else if (pick_ic_s) begin
                    src_s    = SRC_IC;
                    base_s   = icache_addr;
                    n_s      = 3'd4;
                    mem_a_s  = icache_addr;
                    ic_s     = 3'd1;
                    rc_s     = 3'd0;
                    asm_s    = 32'd0;
                    mem_wr_s = 1'b0;
                    pipe_s   = 2'b01;
                    state_s  = MC_READ;
                end else begin
                    state_s  = MC_IDLE;
                end
            end

            MC_READ: begin
                if (frz_r) begin
                    // Bytes in flight were lost during the freeze: start over.
                    mem_a_s = base_r;
                    ic_s    = 3'd1;
                    rc_s    = 3'd0;
                    asm_s   = 32'd0;
                    pipe_s  = 2'b01;
                end else begin
                    if (ic_r < n_r) begin
                        mem_a_s = base_r + ADDR_WIDTH'(ic_r);
                        ic_s    = ic_r + 3'd1;
                        issue_s = 1'b1;
                    end else begin
                        issue_s = 1'b0;
                    end
                    pipe_s = {pipe_r[0], issue_s};
                    if (pipe_r[1]) begin
                        asm_s = asm_nxt_s;
                        rc_s  = rc_r + 3'd1;
                        if (rc_r == (n_r - 3'd1)) begin
                            if (src_r == SRC_LSB) begin
                                lsb_rdata_s = asm_nxt_s;
                                lsb_valid_s = 1'b1;
                            end else begin
                                icache_inst_s  = asm_nxt_s;
                                icache_valid_s = 1'b1;
                            end
                            state_s = MC_DONE;
                        end else begin
                            state_s = MC_READ;
                        end
                    end else begin
                        rc_s = rc_r;
                    end
                end
            end

            MC_WRITE: begin
                if (ic_r < n_r) begin
                    mem_a_s    = base_r + ADDR_WIDTH'(ic_r);
                    mem_dout_s = wdata_r[{ic_r[1:0], 3'b000} +: 8];
                    mem_wr_s   = 1'b1;
                    ic_s       = ic_r + 3'd1;
                end else begin
                    mem_wr_s    = 1'b0;
                    lsb_valid_s = 1'b1;
                    state_s     = MC_DONE;
                end
            end

            MC_DONE: begin
                // Asks are ignored here so the requester has a cycle to drop them.
                mem_wr_s = 1'b0;
                pipe_s   = 2'b00;
                state_s  = MC_IDLE;
            end

            default: begin
                mem_wr_s = 1'b0;
                pipe_s   = 2'b00;
                state_s  = MC_IDLE;
            end
        endcase
    end

    // State and output registers; everything holds while rdy_in is low.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r        <= MC_IDLE;
            src_r          <= SRC_IC;
            base_r         <= '0;
            n_r            <= 3'd0;
            ic_r           <= 3'd0;
            rc_r           <= 3'd0;
            wdata_r        <= 32'd0;
            asm_r          <= 32'd0;
            pipe_r         <= 2'b00;
            frz_r          <= 1'b0;
            mem_a_r        <= '0;
            mem_dout_r     <= 8'd0;
            mem_wr_r       <= 1'b0;
            icache_valid_r <= 1'b0;
            icache_inst_r  <= 32'd0;
            lsb_valid_r    <= 1'b0;
            lsb_rdata_r    <= 32'd0;
        end else if (rdy_in) begin
            state_r        <= state_s;
            src_r          <= src_s;
            base_r         <= base_s;
            n_r            <= n_s;
            ic_r           <= ic_s;
            rc_r           <= rc_s;
            wdata_r        <= wdata_s;
            asm_r          <= asm_s;
            pipe_r         <= pipe_s;
            frz_r          <= 1'b0;
            mem_a_r        <= mem_a_s;
            mem_dout_r     <= mem_dout_s;
            mem_wr_r       <= mem_wr_s;
            icache_valid_r <= icache_valid_s;
            icache_inst_r  <= icache_inst_s;
            lsb_valid_r    <= lsb_valid_s;
            lsb_rdata_r    <= lsb_rdata_s;
        end else begin
            frz_r          <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl with a byte RAM
// model (1-cycle read latency) attached to the memory bus.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic        icache_ask = 1'b0;
    logic [31:0] icache_addr = 32'd0;
    logic        icache_valid;
    logic [31:0] icache_inst;
    logic        lsb_ask = 1'b0;
    logic        lsb_wr = 1'b0;
    logic [31:0] lsb_addr = 32'd0;
    logic [1:0]  lsb_len = 2'd0;
    logic [31:0] lsb_wdata = 32'd0;
    logic        lsb_valid;
    logic [31:0] lsb_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ram [0:262143];
    logic        pre_we = 1'b0;
    logic [17:0] pre_addr = 18'd0;
    logic [7:0]  pre_data = 8'd0;
    int          wr_count = 0;

    mem_ctrl #(.ADDR_WIDTH(32), .LSB_PRIORITY(1'b1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .icache_ask(icache_ask), .icache_addr(icache_addr),
        .icache_valid(icache_valid), .icache_inst(icache_inst),
        .lsb_ask(lsb_ask), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
        .lsb_wdata(lsb_wdata), .lsb_valid(lsb_valid), .lsb_rdata(lsb_rdata)
    );

    always #5 clk_in = ~clk_in;

    // Byte RAM: address sampled on the edge, data available the next cycle.
    always @(posedge clk_in) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (mem_wr) begin
            ram[mem_a[17:0]] <= mem_dout;
            wr_count <= wr_count + 1;
        end
        mem_din <= ram[mem_a[17:0]];
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic poke(input logic [17:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    // Runs until every raised ask is answered; latency k counts edges after
    // the first one (edge 0). Returns -1 for a requester never answered.
    task automatic run_txn(output int ic_lat, output int lsb_lat, output int wr_hi,
                           output logic [31:0] ic_data, output logic [31:0] lsb_data);
        ic_lat = -1; lsb_lat = -1; wr_hi = 0; ic_data = 32'd0; lsb_data = 32'd0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (mem_wr) wr_hi++;
            if (icache_valid) begin
                ic_lat = k; ic_data = icache_inst; icache_ask = 1'b0;
            end
            if (lsb_valid) begin
                lsb_lat = k; lsb_data = lsb_rdata; lsb_ask = 1'b0;
            end
            if (!icache_ask && !lsb_ask) break;
        end
        icache_ask = 1'b0;
        lsb_ask    = 1'b0;
        tick();
        tick();
    endtask

    int          ic_lat, lsb_lat, wr_hi, wr_base;
    logic [31:0] ic_data, lsb_data;
    logic        seen;

    initial begin
        // Reset held while the RAM is preloaded.
        poke(18'h00100, 8'h13); poke(18'h00101, 8'h05);
        poke(18'h00102, 8'ha0); poke(18'h00103, 8'h00);
        poke(18'h00202, 8'hff); poke(18'h00203, 8'h80);
        poke(18'h00010, 8'h5a);
        check_val("rst_mem_a", mem_a, 32'd0);
        check_val("rst_ctl", {22'd0, mem_dout, mem_wr, icache_valid}, 32'd0);
        check_val("rst_inst", icache_inst, 32'd0);
        check_val("rst_rdata", {lsb_rdata[30:0], lsb_valid}, 32'd0);
        rst_in = 1'b0;
        tick();

        // Word fetch: 13 05 a0 00 little-endian.
        icache_addr = 32'h100; icache_ask = 1'b1;
        run_txn(ic_lat, lsb_lat, wr_hi, ic_data, lsb_data);
        check_val("fetch_lat", 32'(ic_lat), 32'd5);
        check_val("fetch_inst", ic_data, 32'h00a00513);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (icache_valid) seen = 1'b1;
        end
        check_val("fetch_no_refetch", {31'd0, seen}, 32'd0);
        check_val("fetch_mem_a_idle", mem_a, 32'h103);

        // Half load, unaligned-friendly byte assembly, no writes.
        wr_base = wr_count;
        lsb_addr = 32'h202; lsb_len = 2'd1; lsb_wr = 1'b0; lsb_ask = 1'b1;
        run_txn(ic_lat, lsb_lat, wr_hi, ic_data, lsb_data);
        check_val("ldh_lat", 32'(lsb_lat), 32'd3);
        check_val("ldh_data", lsb_data, 32'h000080ff);
        check_val("ldh_no_wr", 32'(wr_count - wr_base), 32'd0);

        // Word store then readback.
        wr_base = wr_count;
        lsb_addr = 32'h300; lsb_len = 2'd2; lsb_wr = 1'b1; lsb_wdata = 32'hdeadbeef;
        lsb_ask = 1'b1;
        run_txn(ic_lat, lsb_lat, wr_hi, ic_data, lsb_data);
        check_val("stw_lat", 32'(lsb_lat), 32'd4);
        check_val("stw_wr_cycles", 32'(wr_hi), 32'd4);
        check_val("stw_wr_count", 32'(wr_count - wr_base), 32'd4);
        check_val("stw_ram", {ram[18'h303], ram[18'h302], ram[18'h301], ram[18'h300]},
                  32'hdeadbeef);
        icache_addr = 32'h300; icache_ask = 1'b1;
        run_txn(ic_lat, lsb_lat, wr_hi, ic_data, lsb_data);
        check_val("stw_readback", ic_data, 32'hdeadbeef);

        // Collision: LSB byte load wins; fetch starts on the IDLE after DONE
        // (edge 4), so icache_valid follows edge 9.
        icache_addr = 32'h100; icache_ask = 1'b1;
        lsb_addr = 32'h10; lsb_len = 2'd0; lsb_wr = 1'b0; lsb_ask = 1'b1;
        run_txn(ic_lat, lsb_lat, wr_hi, ic_data, lsb_data);
        check_val("col_lsb_lat", 32'(lsb_lat), 32'd2);
        check_val("col_lsb_data", lsb_data, 32'h0000005a);
        check_val("col_ic_lat", 32'(ic_lat), 32'd9);
        check_val("col_ic_inst", ic_data, 32'h00a00513);

        // IO store blocked while the UART buffer is full.
        wr_base = wr_count;
        io_buffer_full = 1'b1;
        lsb_addr = 32'h30000; lsb_len = 2'd0; lsb_wr = 1'b1; lsb_wdata = 32'h00000077;
        lsb_ask = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (lsb_valid || mem_wr) seen = 1'b1;
        end
        check_val("io_blocked", {31'd0, seen}, 32'd0);
        check_val("io_blocked_wr", 32'(wr_count - wr_base), 32'd0);
        io_buffer_full = 1'b0;
        run_txn(ic_lat, lsb_lat, wr_hi, ic_data, lsb_data);
        check_val("io_lat", 32'(lsb_lat), 32'd1);
        check_val("io_one_wr", 32'(wr_count - wr_base), 32'd1);
        check_val("io_ram", {24'd0, ram[18'h30000]}, 32'h00000077);

        // Freeze for 3 edges mid fetch; READ restarts on resume.
        icache_addr = 32'h100; icache_ask = 1'b1;
        tick(); tick();
        rdy_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (icache_valid || mem_wr) seen = 1'b1;
        end
        check_val("frz_quiet", {31'd0, seen}, 32'd0);
        check_val("frz_mem_a_held", mem_a, 32'h101);
        rdy_in = 1'b1;
        run_txn(ic_lat, lsb_lat, wr_hi, ic_data, lsb_data);
        check_val("frz_resume_lat", 32'(ic_lat), 32'd5);
        check_val("frz_inst", ic_data, 32'h00a00513);

        // Reset after two bytes of a fetch have been captured.
        icache_addr = 32'h100; icache_ask = 1'b1;
        tick(); tick(); tick(); tick();
        rst_in = 1'b1; icache_ask = 1'b0;
        tick();
        check_val("mrst_mem_a", mem_a, 32'd0);
        check_val("mrst_ctl", {22'd0, mem_dout, mem_wr, icache_valid}, 32'd0);
        check_val("mrst_inst", icache_inst, 32'd0);
        check_val("mrst_rdata", {lsb_rdata[30:0], lsb_valid}, 32'd0);
        rst_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (icache_valid) seen = 1'b1;
        end
        check_val("mrst_no_valid", {31'd0, seen}, 32'd0);
        icache_addr = 32'h300; icache_ask = 1'b1;
        run_txn(ic_lat, lsb_lat, wr_hi, ic_data, lsb_data);
        check_val("mrst_refetch_lat", 32'(ic_lat), 32'd5);
        check_val("mrst_refetch", ic_data, 32'hdeadbeef);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Responder side of the instruction-fetch memory interface, plus the load/store path.
- Accepts word fetch requests from the instruction cache and byte/half/word load/store requests from the load-store buffer (LSB).
- Arbitrates between the two and serialises each access onto the byte-wide synchronous RAM/IO bus (one byte per cycle, 1-cycle read latency).
- Returns assembled data with a one-cycle valid pulse.

Parameters:
- ADDR_WIDTH, 32, width of all address ports and mem_a.
- LSB_PRIORITY, 1, 1 = LSB wins when both requesters ask in the same IDLE cycle; 0 = ICache wins.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous, active-high reset.
- rdy_in  in  1  global ready; low freezes the block.
- mem_din  in  8  RAM read byte, valid the cycle after its address was clocked into the RAM.
- mem_dout  out  8  RAM write byte.
- mem_a  out  ADDR_WIDTH  RAM byte address.
- mem_wr  out  1  RAM write strobe, 1 = write.
- io_buffer_full  in  1  UART buffer full.
- icache_ask  in  1  fetch request, level; held until icache_valid is seen.
- icache_addr  in  ADDR_WIDTH  fetch address, word aligned.
- icache_valid  out  1  one-cycle pulse: icache_inst valid.
- icache_inst  out  32  fetched instruction, little-endian.
- lsb_ask  in  1  load/store request, level; held until lsb_valid is seen.
- lsb_wr  in  1  1 = store, 0 = load.
- lsb_addr  in  ADDR_WIDTH  byte address.
- lsb_len  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- lsb_wdata  in  32  store data; low bytes used.
- lsb_valid  out  1  one-cycle pulse: load data ready or store complete.
- lsb_rdata  out  32  load data, zero-extended; sign extension is done by the LSB.

Behaviour:
- Reset (rst_in high at an edge):
  - state = IDLE; counters cleared.
  - All outputs 0: mem_a, mem_dout, mem_wr, icache_valid, icache_inst, lsb_valid, lsb_rdata.
  - Reset mid-transfer abandons the transfer; no valid pulse is produced.
- States: IDLE, READ, WRITE, DONE. Byte counters: issued `ic` (0..N) and received `rc` (0..N); N = 4 for fetch, N = 1/2/4 for LSB.
- IDLE:
  - Select a requester per LSB_PRIORITY; latch source, base address, N, wdata.
  - Load or fetch: mem_a <= base, ic <= 1, rc <= 0, mem_wr <= 0, go to READ.
  - Store: mem_a <= base, mem_dout <= wdata[7:0], mem_wr <= 1, ic <= 1, go to WRITE.
  - A store with lsb_addr[17:16] == 2'b11 while io_buffer_full = 1 is not accepted: stay IDLE; the ICache may be served instead.
- READ, each edge:
  - If ic < N: mem_a <= base + ic, ic++.
  - If the previous edge issued an address: shift mem_din into byte rc of the assembly register, rc++.
  - When byte N-1 is captured: write the result to icache_inst or lsb_rdata, pulse the matching valid, go to DONE.
  - Latency: request sampled at edge E0 -> valid high after edge E(N+1). Word = 5 cycles.
- WRITE, each edge:
  - If ic < N: mem_a <= base + ic, mem_dout <= wdata byte ic, mem_wr <= 1, ic++.
  - Else: mem_wr <= 0, lsb_valid <= 1, go to DONE. Valid high after edge E(N).
- DONE: clear the valid pulse, mem_wr = 0, return to IDLE. Requests are ignored in DONE so a still-high ask is not re-served; the requester drops ask on the edge where it sees valid.
- Address arithmetic: base + ic is ADDR_WIDTH bits, wraps modulo 2^ADDR_WIDTH. No alignment check; unaligned half/word accesses are legal.
- rdy_in low:
  - No state, counter or output register changes.
  - The mem_wr port is the registered strobe ANDed with rdy_in, so no duplicate IO writes occur.
  - On resume in READ, the transfer restarts from byte 0 (ic = rc = 0); bytes already collected are discarded because of RAM pipeline loss.
  - On resume in WRITE, the transfer continues at byte ic.
- lsb_len = 3: treated as word.
- Simultaneous asks: the loser keeps its ask high and is served on the IDLE following DONE. Fairness is not guaranteed; with LSB_PRIORITY = 1 the ICache can starve only while the LSB asks back-to-back.

Decomposition:
- const.v gains:
  - LEN_B = 2'd0, LEN_H = 2'd1, LEN_W = 2'd2;
  - state codes MC_IDLE/MC_READ/MC_WRITE/MC_DONE (2 bits);
  - IO_HI = 2'b11 for addr[17:16].
- No sub-module; byte assembly and the serialiser stay inline in one always block.

Test Plan:
- Fetch: RAM[0x100..0x103] = 13,05,a0,00; icache_ask = 1, addr = 0x100 -> icache_valid high exactly 5 cycles after the request edge, icache_inst = 0x00a00513; no re-fetch while ask drops.
- Load half: RAM[0x202] = 0xff, RAM[0x203] = 0x80; lsb load, len = 1, addr = 0x202 -> lsb_valid after 3 cycles, lsb_rdata = 0x000080ff; mem_wr never 1.
- Store word: wdata = 0xdeadbeef, addr = 0x300 -> mem_wr high 4 consecutive cycles, bytes ef, be, ad, de at 0x300..0x303; lsb_valid on the 5th cycle; a readback fetch returns 0xdeadbeef.
- Collision: icache_ask and lsb_ask (load byte at 0x10) rise on the same edge, LSB_PRIORITY = 1 -> lsb_valid first (after 2 cycles), then DONE, then fetch served; icache_valid 5 cycles after the following IDLE.
- IO back-pressure and freeze:
  - Store byte to 0x30000 with io_buffer_full = 1 for 4 cycles -> no mem_wr; accepted on the first cycle it drops; exactly one mem_wr pulse.
  - rdy_in low for 3 cycles mid word fetch -> correct instruction; latency grows by 3 plus the restart.
- Reset mid-READ after 2 bytes -> all outputs 0 the next cycle, no valid pulse; a new fetch afterwards completes normally.
